// File: rtl/fifo_memory_ext.sv
// fifo_memory_ext: single-clock circular-buffer FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags, and a synchronous flush.
//
// Read mode:
//   FWFT=0  read_data is registered; it updates on the edge that accepts a read.
//   FWFT=1  read_data shows the head word combinationally, or 0 when empty.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   clear              synchronous flush; wins over read and write
//   write_enable/data  push request and word
//   read_enable        pop request
//   read_data          popped word (FWFT=0) or head word (FWFT=1)
//   full, empty        count == DEPTH, count == 0
//   almost_full        count >= AF_LEVEL
//   almost_empty       count <= AE_LEVEL
//   count              occupancy 0..DEPTH
//   overflow           sticky: a write was rejected
//   underflow          sticky: a read was rejected
module fifo_memory_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Threshold sanity, caught at elaboration.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_memory_ext: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_memory_ext: AE_LEVEL out of range 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("fifo_memory_ext: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_q, udf_q;
  logic                  rd_ok, wr_ok;

  // Status is decoded from the registered count only.
  assign full         = (cnt_q == DEPTH_C);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write paired with a read. An empty FIFO never bypasses write to read.
  assign rd_ok = read_enable && !empty;
  assign wr_ok = write_enable && (!full || rd_ok);

  // Storage is not reset; only pointers define valid contents.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (write_enable && !wr_ok) ovf_q <= 1'b1;
      if (read_enable && !rd_ok)  udf_q <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word straight from storage; forced to 0 while nothing is valid.
    assign read_data = empty ? '0 : mem[rd_ptr];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      rd_q <= '0;
      else if (clear) rd_q <= '0;
      else if (rd_ok) rd_q <= mem[rd_ptr];
    end
    assign read_data = rd_q;
  end

endmodule

// File: tb/tb_fifo_memory_ext.sv
module tb_fifo_memory_ext;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic       we = 1'b0;
  logic [7:0] wd = 8'h00;
  logic       re = 1'b0;

  logic [7:0] rd0, rd1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_memory_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut0 (
    .clk(clk), .rstn(rstn), .clear(clear), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  fifo_memory_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) dut1 (
    .clk(clk), .rstn(rstn), .clear(clear), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we = 1'b0; re = 1'b0; clear = 1'b0; wd = 8'h00;
  endtask

  task automatic do_clear;
    idle(); clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) tick();
    @(negedge clk); rstn = 1'b1;
    tick();
    vectors++; if (cnt0 !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", cnt0); end
    vectors++; if ({empty0, ae0, full0, af0} !== 4'b1100) begin miscompares++; $display("FAIL reset_flags0 got %b want 1100", {empty0, ae0, full0, af0}); end
    vectors++; if ({ovf0, udf0} !== 2'b00) begin miscompares++; $display("FAIL reset_err0 got %b want 00", {ovf0, udf0}); end
    vectors++; if (rd0 !== 8'h00) begin miscompares++; $display("FAIL reset_rd0 got %h want 00", rd0); end
    vectors++; if ({empty1, ae1, full1, af1, ovf1, udf1} !== 6'b110000) begin miscompares++; $display("FAIL reset_flags1 got %b want 110000", {empty1, ae1, full1, af1, ovf1, udf1}); end
    vectors++; if (cnt1 !== 5'd0 || rd1 !== 8'h00) begin miscompares++; $display("FAIL reset_fwft got cnt=%0d rd=%h want 0/00", cnt1, rd1); end
  endtask

  task automatic test_fill_overflow;
    do_clear();
    for (int i = 1; i <= 16; i++) begin
      we = 1'b1; wd = 8'(i);
      tick();
      vectors++; if (cnt0 !== 5'(i)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, cnt0, i); end
      vectors++; if (full0 !== (i == 16)) begin miscompares++; $display("FAIL fill_full[%0d] got %b want %b", i, full0, (i == 16)); end
      vectors++; if (af0 !== (i >= 14)) begin miscompares++; $display("FAIL fill_af[%0d] got %b want %b", i, af0, (i >= 14)); end
      vectors++; if (ae0 !== (i <= 2)) begin miscompares++; $display("FAIL fill_ae[%0d] got %b want %b", i, ae0, (i <= 2)); end
    end
    wd = 8'hAA;
    tick();
    idle();
    vectors++; if (ovf0 !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", ovf0); end
    vectors++; if (cnt0 !== 5'd16) begin miscompares++; $display("FAIL ovf_count got %0d want 16", cnt0); end
    vectors++; if (rd1 !== 8'h01) begin miscompares++; $display("FAIL fwft_head_full got %h want 01", rd1); end
    for (int i = 1; i <= 16; i++) begin
      re = 1'b1;
      tick();
      vectors++; if (rd0 !== 8'(i)) begin miscompares++; $display("FAIL drain_rd0[%0d] got %h want %h", i, rd0, 8'(i)); end
      vectors++; if (rd1 !== ((i < 16) ? 8'(i + 1) : 8'h00)) begin miscompares++; $display("FAIL drain_rd1[%0d] got %h want %h", i, rd1, ((i < 16) ? 8'(i + 1) : 8'h00)); end
    end
    idle();
    vectors++; if ({empty0, cnt0} !== {1'b1, 5'd0}) begin miscompares++; $display("FAIL drain_empty got e=%b cnt=%0d want 1/0", empty0, cnt0); end
    vectors++; if (ovf0 !== 1'b1 || udf0 !== 1'b0) begin miscompares++; $display("FAIL ovf_sticky got ovf=%b udf=%b want 1/0", ovf0, udf0); end
  endtask

  task automatic test_full_rw;
    do_clear();
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wd = 8'(8'h21 + i);
      tick();
    end
    vectors++; if (full0 !== 1'b1) begin miscompares++; $display("FAIL frw_full got %b want 1", full0); end
    we = 1'b1; wd = 8'h55; re = 1'b1;
    tick();
    idle();
    vectors++; if (cnt0 !== 5'd16) begin miscompares++; $display("FAIL frw_count got %0d want 16", cnt0); end
    vectors++; if (rd0 !== 8'h21) begin miscompares++; $display("FAIL frw_rd0 got %h want 21", rd0); end
    vectors++; if (ovf0 !== 1'b0) begin miscompares++; $display("FAIL frw_ovf got %b want 0", ovf0); end
    for (int i = 0; i < 16; i++) begin
      re = 1'b1;
      tick();
      vectors++; if (rd0 !== ((i < 15) ? 8'(8'h22 + i) : 8'h55)) begin miscompares++; $display("FAIL frw_drain[%0d] got %h want %h", i, rd0, ((i < 15) ? 8'(8'h22 + i) : 8'h55)); end
    end
    idle();
    vectors++; if (empty0 !== 1'b1) begin miscompares++; $display("FAIL frw_empty got %b want 1", empty0); end
  endtask

  task automatic test_empty_rw;
    // Entered empty with underflow still clear.
    we = 1'b1; wd = 8'h3C; re = 1'b1;
    tick();
    idle();
    vectors++; if (cnt0 !== 5'd1) begin miscompares++; $display("FAIL erw_count got %0d want 1", cnt0); end
    vectors++; if (udf0 !== 1'b1 || udf1 !== 1'b1) begin miscompares++; $display("FAIL erw_udf got %b/%b want 1/1", udf0, udf1); end
    vectors++; if (rd1 !== 8'h3C) begin miscompares++; $display("FAIL erw_fwft got %h want 3c", rd1); end
    tick();
    vectors++; if (rd1 !== 8'h3C || cnt1 !== 5'd1) begin miscompares++; $display("FAIL erw_fwft_hold got rd=%h cnt=%0d want 3c/1", rd1, cnt1); end
    re = 1'b1;
    tick();
    idle();
    vectors++; if (empty1 !== 1'b1 || rd1 !== 8'h00) begin miscompares++; $display("FAIL erw_pop got e=%b rd=%h want 1/00", empty1, rd1); end
    vectors++; if (rd0 !== 8'h3C) begin miscompares++; $display("FAIL erw_rd0 got %h want 3c", rd0); end
  endtask

  task automatic test_clear;
    // Underflow is still set from the previous scenario.
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; wd = 8'(8'h40 + i);
      tick();
    end
    idle();
    vectors++; if (cnt0 !== 5'd9) begin miscompares++; $display("FAIL clr_pre got %0d want 9", cnt0); end
    clear = 1'b1; we = 1'b1; wd = 8'h77;
    tick();
    idle();
    vectors++; if (cnt0 !== 5'd0 || empty0 !== 1'b1) begin miscompares++; $display("FAIL clr_count got cnt=%0d e=%b want 0/1", cnt0, empty0); end
    vectors++; if ({ovf0, udf0} !== 2'b00) begin miscompares++; $display("FAIL clr_err got %b want 00", {ovf0, udf0}); end
    vectors++; if (rd0 !== 8'h00 || rd1 !== 8'h00) begin miscompares++; $display("FAIL clr_rd got %h/%h want 00/00", rd0, rd1); end
    tick();
    vectors++; if (cnt0 !== 5'd0) begin miscompares++; $display("FAIL clr_hold got %0d want 0", cnt0); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; wd = 8'(8'h60 + i);
      tick();
    end
    idle();
    vectors++; if (cnt0 !== 5'd5) begin miscompares++; $display("FAIL ar_pre got %0d want 5", cnt0); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    vectors++; if (cnt0 !== 5'd0 || empty0 !== 1'b1) begin miscompares++; $display("FAIL ar_immediate got cnt=%0d e=%b want 0/1", cnt0, empty0); end
    vectors++; if (rd1 !== 8'h00) begin miscompares++; $display("FAIL ar_fwft got %h want 00", rd1); end
    #1;
    rstn = 1'b1;
    tick();
    re = 1'b1;
    tick();
    idle();
    vectors++; if (udf0 !== 1'b1 || cnt0 !== 5'd0) begin miscompares++; $display("FAIL ar_udf got udf=%b cnt=%0d want 1/0", udf0, cnt0); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_memory_ext.md
Name: fifo_memory_ext

Overview:
- Parametrised successor to the single-clock FIFO (fifo_memory).
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Read data can be either registered (standard) or first-word-fall-through (FWFT), chosen by a mode parameter.
- Used as the general-purpose buffer between producer/consumer stages on one clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; has priority over read and write.
- write_enable  in  1  push request.
- write_data  in  DATA_WIDTH  word to push.
- read_enable  in  1  pop request.
- read_data  out  DATA_WIDTH  popped word (FWFT=0) or head word (FWFT=1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rstn=0, asynchronous):
  - Pointers, count and read_data go to 0; overflow and underflow go to 0.
  - Outputs: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents immediately.
- Storage: circular buffer. Write and read pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0.
- Status outputs (full, empty, almost_full, almost_empty, count) are decoded from the registered count. They therefore reflect state after the most recent clock edge.
- Write is accepted when write_enable=1 and (full=0 or read accepted in the same cycle).
  - Accepted write: mem[wr_ptr] <= write_data, wr_ptr increments.
  - Rejected write: data is dropped and overflow <= 1.
- Read is accepted when read_enable=1 and empty=0.
  - Accepted read: rd_ptr increments.
  - Rejected read: state is unchanged and underflow <= 1.
- Simultaneous write and read:
  - Not empty and not full: both are accepted; count is unchanged.
  - Full: both are accepted; count stays DEPTH, the oldest word is popped and the new word is stored.
  - Empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1. There is no same-cycle bypass.
- count update: +1 on write only, -1 on read only, unchanged otherwise.
- FWFT=0:
  - An accepted read loads read_data <= mem[rd_ptr] at that edge, so data is valid one cycle after the read request.
  - read_data holds its value when no read is accepted.
- FWFT=1:
  - read_data = mem[rd_ptr] combinationally whenever empty=0, and 0 when empty=1.
  - An accepted read advances to the next entry, so the new head is visible after the edge.
  - The first written word appears on read_data the cycle after its write edge.
- clear=1 at an edge:
  - Pointers and count go to 0; overflow and underflow go to 0; read_data goes to 0.
  - Any write or read in that cycle is ignored.
- overflow and underflow remain set until clear or reset.
- The implementation flags illegal AF_LEVEL/AE_LEVEL values with an elaboration-time check.

Test Plan:
- Reset then idle, DEPTH=16 -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, read_data=0.
- Write 0x01..0x10 (16 writes) then a 17th write of 0xAA -> full=1 after the 16th write and almost_full=1 from count=14; the 17th write sets overflow=1 and count stays 16. Then 16 reads (FWFT=0) -> read_data 0x01..0x10 in order, each one cycle after its read; 0xAA never appears.
- From full: write 0x55 and read in the same cycle -> count stays 16. Drain the FIFO -> 0x55 is the last word out, confirming pointer wrap-around.
- From empty, write 0x3C and read in the same cycle -> count=1, underflow=1. With FWFT=1, read_data=0x3C on the next cycle without asserting read_enable; one read gives empty=1 and read_data=0.
- Fill to count=9, assert clear together with write_enable -> next cycle count=0, empty=1, overflow=0, underflow=0, and the write is ignored.
- Fill to count=5, pulse rstn low between clock edges -> count=0 and empty=1 immediately, before the next edge. A read afterwards sets underflow=1.
